// File: rtl/sudoku_input_conditioner.sv
// -----------------------------------------------------------------------------
// sudoku_input_conditioner
//
// Purpose:
//   Input front end for the Sudoku Master game. Each of the four raw direction
//   buttons and the write switch is passed through a 2-flop synchronizer and a
//   counter-based debouncer. Debounced rising edges become clean one-cycle
//   command pulses. Direction presses go through a priority arbiter
//   (up > down > left > right) that locks onto one owner until it is released.
//
// Optional feature:
//   SUDOKU_INPUT_AUTOREPEAT_EN - when defined, a held direction auto-repeats
//   (first repeat after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles).
//   When undefined, each press yields exactly one pulse and the repeat
//   parameters are ignored.
//
// Ports:
//   CLK          in   system clock, rising edge
//   RST          in   synchronous reset, active-low
//   upButton     in   raw button, active-high (also down/left/right)
//   writeSwitch  in   raw write control, active-high
//   upPulse      out  one-cycle move command (also down/left/right)
//   writePulse   out  one-cycle write command on debounced rise of writeSwitch
//   dirHeld      out  high while the direction arbiter is not idle
// -----------------------------------------------------------------------------
module sudoku_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 16,
   parameter int REPEAT_PERIOD   = 8
) (
   input  logic CLK,
   input  logic RST,
   input  logic upButton,
   input  logic downButton,
   input  logic leftButton,
   input  logic rightButton,
   input  logic writeSwitch,
   output logic upPulse,
   output logic downPulse,
   output logic leftPulse,
   output logic rightPulse,
   output logic writePulse,
   output logic dirHeld
);

   localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

   // Channel order: 0 up, 1 down, 2 left, 3 right, 4 write.
   // The lowest index has the highest arbitration priority.
   logic [4:0] w_raw;
   logic [4:0] w_lvl_d;
   logic [4:0] w_rise;

   assign w_raw = {writeSwitch, rightButton, leftButton, downButton, upButton};

   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_chan
         logic        r_sync1;
         logic        r_sync2;
         logic        r_lvl;
         logic        r_lvl_d;
         logic [15:0] r_db_cnt;

         always_ff @(posedge CLK) begin
            if (!RST) begin
               r_sync1  <= 1'b0;
               r_sync2  <= 1'b0;
               r_lvl    <= 1'b0;
               r_lvl_d  <= 1'b0;
               r_db_cnt <= '0;
            end else begin
               r_sync1 <= w_raw[gi];
               r_sync2 <= r_sync1;
               r_lvl_d <= r_lvl;
               // Any sample agreeing with the current level restarts the count.
               if (r_sync2 == r_lvl) begin
                  r_db_cnt <= '0;
               end else if (r_db_cnt == DB_LAST) begin
                  r_lvl    <= ~r_lvl;
                  r_db_cnt <= '0;
               end else begin
                  r_db_cnt <= r_db_cnt + 16'd1;
               end
            end
         end

         // Edges are taken from the level/delayed-level pair so a rise is
         // consumed exactly one cycle after the level flips.
         assign w_lvl_d[gi] = r_lvl_d;
         assign w_rise[gi]  = r_lvl & ~r_lvl_d;
      end
   endgenerate

   // ---------------- write path (independent of arbitration) ----------------
   logic r_write_pulse;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_write_pulse <= 1'b0;
      end else begin
         r_write_pulse <= w_rise[4];
      end
   end

   // ---------------- direction arbitration ----------------
`ifdef SUDOKU_INPUT_AUTOREPEAT_EN
   typedef enum logic [1:0] {S_IDLE, S_HELD, S_REPEAT} state_t;
   localparam logic [15:0] RD_LAST = 16'(REPEAT_DELAY - 1);
   localparam logic [15:0] RP_LAST = 16'(REPEAT_PERIOD - 1);
   logic [15:0] r_rpt_cnt;
`else
   typedef enum logic [1:0] {S_IDLE, S_HELD} state_t;
   logic w_unused_params;
   assign w_unused_params = ^{16'(REPEAT_DELAY), 16'(REPEAT_PERIOD)};
`endif

   state_t     r_state;
   logic [3:0] r_owner;   // one-hot owner, all zero means none
   logic [3:0] r_pulse;
   logic       r_dir_held;
   logic [3:0] w_dir_rise;
   logic [3:0] w_win;
   logic       w_owner_lvl;

   assign w_dir_rise  = w_rise[3:0];
   // Isolate the lowest set bit: highest-priority rising direction.
   assign w_win       = w_dir_rise & (~w_dir_rise + 4'd1);
   // Release is judged on the delayed level, one cycle behind the debouncer.
   assign w_owner_lvl = |(r_owner & w_lvl_d[3:0]);

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state    <= S_IDLE;
         r_owner    <= '0;
         r_pulse    <= '0;
         r_dir_held <= 1'b0;
`ifdef SUDOKU_INPUT_AUTOREPEAT_EN
         r_rpt_cnt  <= '0;
`endif
      end else begin
         r_pulse <= '0;
         case (r_state)
            S_IDLE: begin
               if (|w_dir_rise) begin
                  r_pulse    <= w_win;
                  r_owner    <= w_win;
                  r_state    <= S_HELD;
                  r_dir_held <= 1'b1;
`ifdef SUDOKU_INPUT_AUTOREPEAT_EN
                  r_rpt_cnt  <= '0;
`endif
               end
            end
            S_HELD: begin
               if (!w_owner_lvl) begin
                  r_state    <= S_IDLE;
                  r_owner    <= '0;
                  r_dir_held <= 1'b0;
               end
`ifdef SUDOKU_INPUT_AUTOREPEAT_EN
               else if (r_rpt_cnt == RD_LAST) begin
                  r_pulse   <= r_owner;
                  r_rpt_cnt <= '0;
                  r_state   <= S_REPEAT;
               end else begin
                  r_rpt_cnt <= r_rpt_cnt + 16'd1;
               end
`endif
            end
`ifdef SUDOKU_INPUT_AUTOREPEAT_EN
            S_REPEAT: begin
               if (!w_owner_lvl) begin
                  r_state    <= S_IDLE;
                  r_owner    <= '0;
                  r_dir_held <= 1'b0;
               end else if (r_rpt_cnt == RP_LAST) begin
                  r_pulse   <= r_owner;
                  r_rpt_cnt <= '0;
               end else begin
                  r_rpt_cnt <= r_rpt_cnt + 16'd1;
               end
            end
`endif
            default: begin
               r_state    <= S_IDLE;
               r_owner    <= '0;
               r_dir_held <= 1'b0;
            end
         endcase
      end
   end

   assign upPulse    = r_pulse[0];
   assign downPulse  = r_pulse[1];
   assign leftPulse  = r_pulse[2];
   assign rightPulse = r_pulse[3];
   assign writePulse = r_write_pulse;
   assign dirHeld    = r_dir_held;

endmodule
